// File: rtl/display_pkg.sv
// Shared framebuffer geometry and pixel-writer FSM state type.
package display_pkg;

  localparam int unsigned FB_WIDTH  = 320;
  localparam int unsigned FB_HEIGHT = 240;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WRITE = 2'd2
  } draw_state_t;

  function automatic logic off_screen(input int unsigned x, input int unsigned y);
    return (x >= FB_WIDTH) || (y >= FB_HEIGHT);
  endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Registered framebuffer address: base + y*FB_WIDTH + x, wrapping modulo 2^AW.
// With DRAW_CLIP_EN defined it also registers an off-screen flag for the point.
module fb_addr_calc
  import display_pkg::*;
#(
  parameter int N  = 10,
  parameter int AW = 17
) (
  input  logic                clkSYS,
  input  logic                n_reset,
  input  logic                load,
  input  logic [1:0][N-1:0]   pt,
  input  logic [AW-1:0]       base,
  output logic [AW-1:0]       addr,
  output logic                oob
);

  // Loaded on the accept edge so the result is ready while the writer sits in ADDR.
  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      addr <= '0;
      oob  <= 1'b0;
    end else if (load) begin
      addr <= base + AW'(pt[1]) * AW'(FB_WIDTH) + AW'(pt[0]);
`ifdef DRAW_CLIP_EN
      oob  <= off_screen(32'(pt[0]), 32'(pt[1]));
`else
      oob  <= 1'b0;
`endif
    end
  end

endmodule

// File: rtl/draw_pixel_writer.sv
// Pops points from the line generator and issues one framebuffer write per point.
// Build option DRAW_CLIP_EN: off-screen points are dropped without a write.
module draw_pixel_writer
  import display_pkg::*;
#(
  parameter int N  = 10,
  parameter int AW = 17,
  parameter int DW = 16
) (
  input  logic              clkSYS,
  input  logic              n_reset,
  input  logic [1:0][N-1:0] pt,
  input  logic              pt_valid,
  output logic              pt_next,
  input  logic              line_done,
  input  logic [DW-1:0]     colour,
  input  logic [AW-1:0]     base,
  output logic              mem_req,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_data,
  input  logic              mem_ack,
  output logic              done,
  output logic [15:0]       count
);

  draw_state_t   state, next_state;
  logic          accept, issue, retire, fire_done, clip;
  logic          done_pending;
  logic [AW-1:0] calc_addr;
  logic [DW-1:0] colour_q;

  fb_addr_calc #(.N(N), .AW(AW)) u_addr_calc (
    .clkSYS  (clkSYS),
    .n_reset (n_reset),
    .load    (accept),
    .pt      (pt),
    .base    (base),
    .addr    (calc_addr),
    .oob     (clip)
  );

  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= next_state;
  end

  // done fires on whichever edge lands the FSM in IDLE, including staying there.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    issue      = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE: begin
        if (pt_valid) begin
          accept     = 1'b1;
          next_state = ADDR;
        end
      end
      ADDR: begin
        if (clip) begin
          next_state = IDLE;
        end else begin
          issue      = 1'b1;
          next_state = WRITE;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          retire     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    fire_done = (next_state == IDLE) && (done_pending || line_done);
  end

  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      pt_next      <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      done         <= 1'b0;
      count        <= 16'd0;
      done_pending <= 1'b0;
      colour_q     <= '0;
    end else begin
      pt_next      <= accept;
      done         <= fire_done;
      done_pending <= (done_pending || line_done) && !fire_done;
      if (accept) colour_q <= colour;
      if (issue) begin
        mem_req  <= 1'b1;
        mem_addr <= calc_addr;
        mem_data <= colour_q;
      end
      if (retire) begin
        mem_req <= 1'b0;
        count   <= count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_draw_pixel_writer.sv
// Self-checking bench for draw_pixel_writer: vector table, hand sequences and random points.
module tb_draw_pixel_writer;

  localparam int N  = 10;
  localparam int AW = 17;
  localparam int DW = 16;
  localparam int SCR_W = 320;
  localparam int SCR_H = 240;
`ifdef DRAW_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  logic              clkSYS;
  logic              n_reset;
  logic [1:0][N-1:0] pt;
  logic              pt_valid;
  logic              pt_next;
  logic              line_done;
  logic [DW-1:0]     colour;
  logic [AW-1:0]     base;
  logic              mem_req;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_data;
  logic              mem_ack;
  logic              done;
  logic [15:0]       count;

  int checks = 0;
  int failures = 0;
  int exp_count = 0;
  int done_pulses = 0;

  typedef struct {
    int x;
    int y;
    int b;
    int col;
    int delay;
    int addr;
    bit oob;
  } vec_t;

  vec_t vecs[9];

  draw_pixel_writer #(.N(N), .AW(AW), .DW(DW)) dut (
    .clkSYS    (clkSYS),
    .n_reset   (n_reset),
    .pt        (pt),
    .pt_valid  (pt_valid),
    .pt_next   (pt_next),
    .line_done (line_done),
    .colour    (colour),
    .base      (base),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ack   (mem_ack),
    .done      (done),
    .count     (count)
  );

  initial begin
    clkSYS = 1'b0;
    forever #5 clkSYS = ~clkSYS;
  end

  always @(negedge clkSYS) if (done) done_pulses++;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int model_addr(input int x, input int y, input int b);
    return (b + y * SCR_W + x) % (1 << AW);
  endfunction

  function automatic bit model_clip(input int x, input int y);
    return CLIP_EN && ((x >= SCR_W) || (y >= SCR_H));
  endfunction

  task automatic tick();
    @(posedge clkSYS);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Drives one point through accept/address/write and checks every stage.
  task automatic apply_stimulus(input int x, input int y, input int b, input int col,
                                input int delay, input int exp_addr, input bit clip,
                                input bit hold_valid, input bit ld, input bit exp_done,
                                input string tag);
    bit got;
    pt[0]     = N'(x);
    pt[1]     = N'(y);
    colour    = DW'(col);
    base      = AW'(b);
    pt_valid  = 1'b1;
    line_done = ld;
    mem_ack   = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      line_done = 1'b0;
      if (pt_next) got = 1'b1;
    end
    check_output({tag, "_pt_next"}, 32'(got), 32'd1);
    if (!got) begin
      pt_valid = 1'b0;
      return;
    end
    if (!hold_valid) pt_valid = 1'b0;
    colour = ~colour;
    base   = base ^ 17'h1555;
    pt[0]  = ~pt[0];
    tick();
    if (clip) begin
      check_output({tag, "_clip_req"}, 32'(mem_req), 32'd0);
      check_output({tag, "_clip_done"}, 32'(done), 32'(exp_done));
      tick();
      check_output({tag, "_clip_req2"}, 32'(mem_req), 32'd0);
      check_output({tag, "_clip_count"}, 32'(count), 32'(exp_count));
    end else begin
      check_output({tag, "_req"}, 32'(mem_req), 32'd1);
      check_output({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
      check_output({tag, "_data"}, 32'(mem_data), 32'(col & 16'hFFFF));
      for (int i = 0; i < delay; i++) begin
        tick();
        check_output({tag, "_hold_flags"}, 32'({mem_req, pt_next, done}), 32'b100);
        check_output({tag, "_hold_addr"}, 32'({mem_addr, mem_data}),
                     32'({AW'(exp_addr), DW'(col)}));
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      exp_count = (exp_count + 1) & 16'hFFFF;
      check_output({tag, "_req_drop"}, 32'(mem_req), 32'd0);
      check_output({tag, "_count"}, 32'(count), 32'(exp_count));
      check_output({tag, "_done"}, 32'(done), 32'(exp_done));
    end
    pt_valid = 1'b0;
  endtask

  initial begin
    bit got;
    int pulses, d0, x, y, b, col, dly;
    logic quiet;

    vecs[0] = '{3,    2,    0,      'h1234, 0, 643,   1'b0};
    vecs[1] = '{0,    0,    0,      'hFFFF, 1, 0,     1'b0};
    vecs[2] = '{319,  239,  0,      'h0001, 2, 76799, 1'b0};
    vecs[3] = '{320,  0,    0,      'hA5A5, 0, 320,   1'b1};
    vecs[4] = '{0,    240,  0,      'h5A5A, 0, 76800, 1'b1};
    vecs[5] = '{400,  5,    0,      'h00FF, 0, 2000,  1'b1};
    vecs[6] = '{1,    1,    100,    'h0F0F, 0, 421,   1'b0};
    vecs[7] = '{1,    0,    131071, 'hF00D, 3, 0,     1'b0};
    vecs[8] = '{1023, 1023, 0,      'hCAFE, 0, 66239, 1'b1};

    n_reset = 1'b0; pt = '0; pt_valid = 1'b0; line_done = 1'b0;
    colour = '0; base = '0; mem_ack = 1'b0;
    #12;
    check_output("rst_flags", 32'({pt_next, mem_req, done}), 32'd0);
    check_output("rst_addr", 32'(mem_addr), 32'd0);
    check_output("rst_data", 32'(mem_data), 32'd0);
    check_output("rst_count", 32'(count), 32'd0);
    @(posedge clkSYS); #1;
    n_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      quiet = pt_next | mem_req | done | (|mem_addr) | (|mem_data) | (|count);
      check_output("post_rst_quiet", 32'(quiet), 32'd0);
    end

    $display("[TB] vector table");
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].x, vecs[i].y, vecs[i].b, vecs[i].col, vecs[i].delay,
                     vecs[i].addr, CLIP_EN && vecs[i].oob, 1'b0, 1'b0, 1'b0,
                     $sformatf("vec%0d", i));
    end

    $display("[TB] ack delayed 4 cycles with pt_valid held");
    apply_stimulus(3, 2, 0, 'hBEEF, 4, 643, 1'b0, 1'b1, 1'b0, 1'b0, "slow_ack");

    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    mem_ack = 1'b0;
    check_output("idle_ack_count", 32'(count), 32'(exp_count));
    check_output("idle_ack_req", 32'(mem_req), 32'd0);

    d0 = done_pulses;
    line_done = 1'b1;
    tick();
    line_done = 1'b0;
    check_output("idle_done", 32'(done), 32'd1);
    tick();
    check_output("idle_done_width", 32'(done), 32'd0);
    check_output("idle_done_pulses", 32'(done_pulses - d0), 32'd1);

    $display("[TB] throughput with ack tied high");
    pt[0] = 10'd5; pt[1] = 10'd1; base = '0; colour = 16'h7777;
    pt_valid = 1'b1; mem_ack = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (pt_next) pulses++;
    end
    pt_valid = 1'b0; mem_ack = 1'b0;
    exp_count = (exp_count + 4) & 16'hFFFF;
    check_output("tput_pops", 32'(pulses), 32'd4);
    check_output("tput_count", 32'(count), 32'(exp_count));
    tick();
    tick();

    $display("[TB] line (0,0)->(4,0)");
    d0 = done_pulses;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(i, 0, 0, 'h0C0C, 0, i, 1'b0, 1'b0, (i == 4), (i == 4),
                     $sformatf("line%0d", i));
    end
    tick();
    check_output("line_done_width", 32'(done), 32'd0);
    check_output("line_done_pulses", 32'(done_pulses - d0), 32'd1);

    $display("[TB] random points");
    for (int i = 0; i < 40; i++) begin
      x   = int'($urandom_range(0, 399));
      y   = int'($urandom_range(0, 299));
      b   = int'($urandom_range(0, 131071));
      col = int'($urandom_range(0, 65535));
      dly = int'($urandom_range(0, 3));
      apply_stimulus(x, y, b, col, dly, model_addr(x, y, b), model_clip(x, y),
                     1'b0, 1'b0, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("[TB] reset during WRITE");
    d0 = done_pulses;
    pt[0] = 10'd7; pt[1] = 10'd7; base = '0; colour = 16'h1111;
    pt_valid = 1'b1; mem_ack = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (pt_next) got = 1'b1;
    end
    check_output("rst_wr_accept", 32'(got), 32'd1);
    pt_valid = 1'b0;
    tick();
    check_output("rst_wr_req_before", 32'(mem_req), 32'd1);
    line_done = 1'b1;
    tick();
    line_done = 1'b0;
    #2;
    n_reset = 1'b0;
    #1;
    check_output("rst_wr_req", 32'(mem_req), 32'd0);
    check_output("rst_wr_count", 32'(count), 32'd0);
    check_output("rst_wr_addr", 32'(mem_addr), 32'd0);
    exp_count = 0;
    tick();
    tick();
    n_reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_output("rst_wr_no_done", 32'(done_pulses - d0), 32'd0);
    apply_stimulus(3, 2, 0, 'h2222, 1, 643, 1'b0, 1'b0, 1'b0, 1'b0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
